// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with byte-serial 8-bit RAM port
module mem_stage #(
  parameter int            AW     = 8,
  parameter logic [AW-1:0] OP_LB  = 8'h20,
  parameter logic [AW-1:0] OP_LH  = 8'h21,
  parameter logic [AW-1:0] OP_LW  = 8'h22,
  parameter logic [AW-1:0] OP_LBU = 8'h24,
  parameter logic [AW-1:0] OP_LHU = 8'h25,
  parameter logic [AW-1:0] OP_SB  = 8'h28,
  parameter logic [AW-1:0] OP_SH  = 8'h29,
  parameter logic [AW-1:0] OP_SW  = 8'h2A
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic [4:0]    mem_wd_i,
  input  logic          mem_wreg_i,
  input  logic [31:0]   mem_data_i,
  input  logic [31:0]   mem_addr_i,
  input  logic [AW-1:0] aluop_i,
  output logic [4:0]    wd_o,
  output logic          wreg_o,
  output logic [31:0]   wdata_o,
  output logic [31:0]   ram_a_o,
  output logic [7:0]    ram_dout_o,
  output logic          ram_wr_o,
  input  logic [7:0]    ram_din_i,
  output logic          stall_req_o
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [31:0] buf_q;

  logic [2:0]  size;
  logic        is_load;
  logic        is_mem;
  logic [1:0]  rd_byte;
  logic [31:0] addr_cur;
  logic [31:0] addr_prev;
  logic [7:0]  store_byte;
  logic [31:0] load_val;
  logic        stall;

  // Decode transfer size (bytes) and direction; size 0 marks a non-memory op
  always_comb begin
    size    = 3'd0;
    is_load = 1'b0;
    case (aluop_i)
      OP_LB, OP_LBU: begin size = 3'd1; is_load = 1'b1; end
      OP_LH, OP_LHU: begin size = 3'd2; is_load = 1'b1; end
      OP_LW:         begin size = 3'd4; is_load = 1'b1; end
      OP_SB:         size = 3'd1;
      OP_SH:         size = 3'd2;
      OP_SW:         size = 3'd4;
      default:       ;
    endcase
  end

  assign is_mem     = (size != 3'd0);
  // cnt runs 1..4 in RD; the low two bits minus one give the byte being captured
  assign rd_byte    = cnt_q[1:0] - 2'd1;
  assign addr_cur   = mem_addr_i + {29'd0, cnt_q};
  assign addr_prev  = mem_addr_i + {29'd0, cnt_q} - 32'd1;
  assign store_byte = mem_data_i[{cnt_q[1:0], 3'b000} +: 8];

  // Extend the assembled little-endian load buffer to the register width
  always_comb begin
    load_val = buf_q;
    case (aluop_i)
      OP_LB:   load_val = {{24{buf_q[7]}}, buf_q[7:0]};
      OP_LBU:  load_val = {24'd0, buf_q[7:0]};
      OP_LH:   load_val = {{16{buf_q[15]}}, buf_q[15:0]};
      OP_LHU:  load_val = {16'd0, buf_q[15:0]};
      default: ;
    endcase
  end

  // Drive the MEM/WB and RAM side; byte 0 is issued straight from IDLE
  always_comb begin
    wd_o        = mem_wd_i;
    wreg_o      = mem_wreg_i;
    wdata_o     = mem_data_i;
    ram_a_o     = mem_addr_i;
    ram_dout_o  = 8'h00;
    ram_wr_o    = 1'b0;
    stall       = 1'b0;
    if (is_mem) begin
      stall = (state_q != DONE);
      case (state_q)
        IDLE: begin
          if (rdy && !is_load) begin
            ram_wr_o   = 1'b1;
            ram_dout_o = mem_data_i[7:0];
          end
        end
        WR: begin
          ram_a_o    = addr_cur;
          ram_dout_o = store_byte;
          ram_wr_o   = rdy;
        end
        // While frozen keep the address whose data is still owed, so the
        // capture after rdy returns sees the right byte
        RD:      ram_a_o = rdy ? addr_cur : addr_prev;
        DONE:    if (is_load) wdata_o = load_val;
        default: ;
      endcase
      if (stall) wreg_o = 1'b0;
    end
    stall_req_o = stall;
    if (!rst) begin
      wd_o        = 5'd0;
      wreg_o      = 1'b0;
      wdata_o     = 32'd0;
      ram_a_o     = 32'd0;
      ram_dout_o  = 8'h00;
      ram_wr_o    = 1'b0;
      stall_req_o = 1'b0;
    end
  end

  // Access sequencer: byte counter, load buffer and state, all frozen by rdy low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      buf_q   <= 32'd0;
    end else if (rdy) begin
      case (state_q)
        IDLE: begin
          if (is_mem) begin
            cnt_q <= 3'd1;
            buf_q <= 32'd0;
            if (is_load)            state_q <= RD;
            else if (size == 3'd1)  state_q <= DONE;
            else                    state_q <= WR;
          end
        end
        WR: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == size - 3'd1) state_q <= DONE;
        end
        RD: begin
          buf_q[{rd_byte, 3'b000} +: 8] <= ram_din_i;
          if (cnt_q == size) state_q <= DONE;
          else               cnt_q   <= cnt_q + 3'd1;
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= 3'd0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a cycle-timeline model
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_addr_i;
  logic [7:0]  aluop_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] ram_a_o;
  logic [7:0]  ram_dout_o;
  logic        ram_wr_o;
  logic [7:0]  ram_din_i;
  logic        stall_req_o;

  mem_stage dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_data_i(mem_data_i),
    .mem_addr_i(mem_addr_i), .aluop_i(aluop_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .ram_a_o(ram_a_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o),
    .ram_din_i(ram_din_i), .stall_req_o(stall_req_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected behaviour of one cycle
  typedef struct packed {
    logic        rdy;
    logic        stall;
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic [31:0] a;
    logic        a_chk;
    logic        wr;
    logic [7:0]  dout;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        cur;
  logic        chk_valid;
  int          n_chk;
  int          n_fail;
  logic [7:0]  ram [logic [31:0]];

  // Byte-wide RAM, read data valid the cycle after the address
  always @(posedge clk) begin
    ram_din_i <= ram.exists(ram_a_o) ? ram[ram_a_o] : 8'h00;
    if (ram_wr_o) ram[ram_a_o] = ram_dout_o;
  end

  function automatic logic [7:0] rd_ram(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic int size_of(input logic [7:0] op);
    case (op)
      8'h20, 8'h24, 8'h28: return 1;
      8'h21, 8'h25, 8'h29: return 2;
      8'h22, 8'h2A:        return 4;
      default:             return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic r, input logic st, input logic wg, input logic [4:0] wd,
                      input logic [31:0] wdat, input logic [31:0] a, input logic ac,
                      input logic wr, input logic [7:0] dout);
    rec_t x;
    x.rdy = r; x.stall = st; x.wreg = wg; x.wd = wd; x.wdata = wdat;
    x.a = a; x.a_chk = ac; x.wr = wr; x.dout = dout;
    exp_q.push_back(x);
  endtask

  // Build the cycle timeline of one op from the access rules and the rdy pattern
  task automatic gen_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] pat,
                        output logic [31:0] res);
    int          n;
    int          c;
    logic        ld;
    logic [31:0] v;
    logic [31:0] sh;
    n  = size_of(op);
    ld = (op < 8'h28);
    c  = 0;
    if (n == 0) begin
      res = data;
      push(1'b1, 1'b0, wreg, wd, data, addr, 1'b1, 1'b0, 8'h00);
      return;
    end
    while (!pat[c[4:0]]) begin
      push(1'b0, 1'b1, 1'b0, wd, 32'd0, addr, 1'b1, 1'b0, 8'h00); c++;
    end
    if (!ld) begin
      for (int k = 0; k < n; k++) begin
        while (!pat[c[4:0]]) begin
          push(1'b0, 1'b1, 1'b0, wd, 32'd0, addr + k, 1'b1, 1'b0, 8'h00); c++;
        end
        sh = data >> (8 * k);
        push(1'b1, 1'b1, 1'b0, wd, 32'd0, addr + k, 1'b1, 1'b1, sh[7:0]); c++;
      end
      res = data;
    end else begin
      push(1'b1, 1'b1, 1'b0, wd, 32'd0, addr, 1'b1, 1'b0, 8'h00); c++;
      v = 32'd0;
      for (int j = 0; j < n; j++) begin
        while (!pat[c[4:0]]) begin
          push(1'b0, 1'b1, 1'b0, wd, 32'd0, addr + j, 1'b1, 1'b0, 8'h00); c++;
        end
        push(1'b1, 1'b1, 1'b0, wd, 32'd0, addr + j + 1, (j + 1 < n), 1'b0, 8'h00); c++;
        v = v | ({24'd0, rd_ram(addr + j)} << (8 * j));
      end
      case (op)
        8'h20:   res = {{24{v[7]}}, v[7:0]};
        8'h21:   res = {{16{v[15]}}, v[15:0]};
        8'h24:   res = {24'd0, v[7:0]};
        8'h25:   res = {16'd0, v[15:0]};
        default: res = v;
      endcase
    end
    push(1'b1, 1'b0, wreg, wd, res, addr, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] pat,
                        output logic [31:0] res, output int ncyc);
    rec_t r;
    gen_op(op, addr, data, wd, wreg, pat, res);
    ncyc = exp_q.size();
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      @(negedge clk);
      aluop_i    = op;
      mem_addr_i = addr;
      mem_data_i = data;
      mem_wd_i   = wd;
      mem_wreg_i = wreg;
      rdy        = r.rdy;
      cur        = r;
      chk_valid  = 1'b1;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, {31'd0, stall_req_o}, 32'd0);
    chk({tag, "_wr"},    {31'd0, ram_wr_o},    32'd0);
    chk({tag, "_wdata"}, wdata_o,              32'd0);
    chk({tag, "_a"},     ram_a_o,              32'd0);
    chk({tag, "_dout"},  {24'd0, ram_dout_o},  32'd0);
    chk({tag, "_wd"},    {27'd0, wd_o},        32'd0);
    chk({tag, "_wreg"},  {31'd0, wreg_o},      32'd0);
  endtask

  // Compare the DUT against the current timeline entry, mid-cycle
  always @(negedge clk) begin
    #2;
    if (chk_valid) begin
      chk("stall", {31'd0, stall_req_o}, {31'd0, cur.stall});
      chk("wreg",  {31'd0, wreg_o},      {31'd0, cur.wreg});
      chk("wd",    {27'd0, wd_o},        {27'd0, cur.wd});
      chk("ram_wr", {31'd0, ram_wr_o},   {31'd0, cur.wr});
      if (cur.a_chk) chk("ram_a", ram_a_o, cur.a);
      if (cur.wr)    chk("ram_dout", {24'd0, ram_dout_o}, {24'd0, cur.dout});
      if (!cur.stall) chk("wdata", wdata_o, cur.wdata);
    end
  end

  logic [31:0] res;
  int          ncyc;

  initial begin
    n_chk = 0; n_fail = 0; chk_valid = 1'b0;
    rst = 1'b0; rdy = 1'b1;
    aluop_i = 8'h22; mem_addr_i = 32'h0000_0100; mem_data_i = 32'hDEAD_BEEF;
    mem_wd_i = 5'd3; mem_wreg_i = 1'b1;
    ram[32'h0000_0100] = 8'h78; ram[32'h0000_0101] = 8'h56;
    ram[32'h0000_0102] = 8'h34; ram[32'h0000_0103] = 8'h12;
    ram[32'h0000_0010] = 8'h80;
    ram[32'h0000_0200] = 8'h34; ram[32'h0000_0201] = 8'h9A;
    ram[32'h0000_0302] = 8'hEE; ram[32'h0000_0303] = 8'hEE;

    @(negedge clk); #1;
    chk_zero("reset");
    @(negedge clk);
    aluop_i = 8'h01; mem_data_i = 32'h1234; mem_wd_i = 5'd5; rst = 1'b1;

    run_op(8'h01, 32'h0000_0040, 32'h0000_1234, 5'd5, 1'b1, 32'hFFFF_FFFF, res, ncyc);
    chk("add_res", res, 32'h0000_1234);
    chk("add_cycles", ncyc, 1);

    run_op(8'h22, 32'h0000_0100, 32'h0, 5'd6, 1'b1, 32'hFFFF_FFFF, res, ncyc);
    chk("lw_res", res, 32'h1234_5678);
    chk("lw_cycles", ncyc, 6);

    run_op(8'h20, 32'h0000_0010, 32'h0, 5'd7, 1'b1, 32'hFFFF_FFFF, res, ncyc);
    chk("lb_res", res, 32'hFFFF_FF80);
    chk("lb_cycles", ncyc, 3);

    run_op(8'h24, 32'h0000_0010, 32'h0, 5'd8, 1'b1, 32'hFFFF_FFFF, res, ncyc);
    chk("lbu_res", res, 32'h0000_0080);
    chk("lbu_cycles", ncyc, 3);

    run_op(8'h2A, 32'hFFFF_FFFE, 32'hAABB_CCDD, 5'd9, 1'b0, 32'hFFFF_FFFF, res, ncyc);
    chk("sw_cycles", ncyc, 5);
    chk("sw_b0", {24'd0, rd_ram(32'hFFFF_FFFE)}, 32'h0000_00DD);
    chk("sw_b1", {24'd0, rd_ram(32'hFFFF_FFFF)}, 32'h0000_00CC);
    chk("sw_b2", {24'd0, rd_ram(32'h0000_0000)}, 32'h0000_00BB);
    chk("sw_b3", {24'd0, rd_ram(32'h0000_0001)}, 32'h0000_00AA);

    run_op(8'h21, 32'h0000_0200, 32'h0, 5'd10, 1'b1, 32'hFFFF_FFF9, res, ncyc);
    chk("lh_res", res, 32'hFFFF_9A34);
    chk("lh_cycles", ncyc, 6);

    run_op(8'h25, 32'h0000_0200, 32'h0, 5'd11, 1'b1, 32'hFFFF_FFFF, res, ncyc);
    chk("lhu_res", res, 32'h0000_9A34);

    run_op(8'h24, 32'h0000_0010, 32'h0, 5'd12, 1'b1, 32'hFFFF_FFFE, res, ncyc);
    chk("lbu_wait_cycles", ncyc, 4);

    run_op(8'h28, 32'h0000_0020, 32'h0000_0055, 5'd13, 1'b0, 32'hFFFF_FFFF, res, ncyc);
    chk("sb_cycles", ncyc, 2);
    chk("sb_byte", {24'd0, rd_ram(32'h0000_0020)}, 32'h0000_0055);

    run_op(8'h29, 32'h0000_0030, 32'h0000_BEEF, 5'd14, 1'b0, 32'hFFFF_FFFF, res, ncyc);
    chk("sh_b0", {24'd0, rd_ram(32'h0000_0030)}, 32'h0000_00EF);
    chk("sh_b1", {24'd0, rd_ram(32'h0000_0031)}, 32'h0000_00BE);

    @(negedge clk);
    chk_valid = 1'b0;
    aluop_i = 8'h2A; mem_addr_i = 32'h0000_0300; mem_data_i = 32'h1122_3344;
    mem_wd_i = 5'd15; mem_wreg_i = 1'b0; rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (3) @(negedge clk);
    chk("rst_b0", {24'd0, rd_ram(32'h0000_0300)}, 32'h0000_0044);
    chk("rst_b1", {24'd0, rd_ram(32'h0000_0301)}, 32'h0000_0033);
    chk("rst_b2", {24'd0, rd_ram(32'h0000_0302)}, 32'h0000_00EE);
    chk("rst_b3", {24'd0, rd_ram(32'h0000_0303)}, 32'h0000_00EE);
    aluop_i = 8'h01;
    rst = 1'b1;

    run_op(8'h22, 32'h0000_0300, 32'h0, 5'd16, 1'b1, 32'hFFFF_FFFF, res, ncyc);
    chk("post_rst_lw", res, 32'hEEEE_3344);

    @(negedge clk);
    chk_valid = 1'b0;
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
